// File: rtl/fifo_line_rd_ctrl.sv
// Read-side line controller: waits for FIFO fill, pops one line, streams it with sol/eol.
// Optional FIFO_LINE_RD_UNDERRUN_CNT_EN adds the saturating underrun_cnt_o counter.
module fifo_line_rd_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WIDTH = 10,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned LINE_LEN    = 640,
    parameter int unsigned START_LEVEL = 16,
    parameter int unsigned SKID_DEPTH  = 4
) (
    input  logic                  rd_clk_i,
    input  logic                  rd_rst_i,
    input  logic                  line_req_i,
    output logic                  busy_o,
    output logic                  line_done_o,
    output logic                  underrun_o,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_rd_empty_i,
    input  logic [DEPTH_WIDTH:0]  fifo_rd_water_level_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_sol_o,
`ifdef FIFO_LINE_RD_UNDERRUN_CNT_EN
    output logic                  out_eol_o,
    output logic [15:0]           underrun_cnt_o
`else
    output logic                  out_eol_o
`endif
);

    localparam int unsigned PtrW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(SKID_DEPTH + RD_LATENCY + 1);

    localparam logic [11:0]            LastBeat  = 12'(LINE_LEN - 1);
    localparam logic [DEPTH_WIDTH:0]   StartLvl  = (DEPTH_WIDTH + 1)'(START_LEVEL);
    localparam logic [CntW-1:0]        SkidDepth = CntW'(SKID_DEPTH);
    localparam logic [PtrW-1:0]        PtrLast   = PtrW'(SKID_DEPTH - 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWaitLvl = 2'd1;
    localparam logic [1:0] StStream  = 2'd2;
    localparam logic [1:0] StDrain   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [11:0]           pop_cnt_q, pop_cnt_d;
    logic [11:0]           beat_q, beat_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0] skid_mem_q [SKID_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       skid_cnt_q, skid_cnt_d;
    logic [CntW-1:0]       inflight;
    logic                  line_done_q;
    logic                  accept, rd_en, skid_push, hs, eol_hs;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + CntW'(vld_q[i]);
        end
    end

    // Credit covers words still in the read pipe, so the skid can never overflow.
    assign accept    = (state_q == StIdle) & line_req_i;
    assign rd_en     = (state_q == StStream) & ~fifo_rd_empty_i &
                       ((inflight + skid_cnt_q) < SkidDepth);
    assign skid_push = vld_q[RD_LATENCY-1];
    assign hs        = out_valid_o & out_ready_i;
    assign eol_hs    = hs & (beat_q == LastBeat);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (line_req_i) state_d = StWaitLvl;
            StWaitLvl: if ((fifo_rd_water_level_i >= StartLvl) && !fifo_rd_empty_i) begin
                state_d = StStream;
            end
            StStream:  if (rd_en && (pop_cnt_q == LastBeat)) state_d = StDrain;
            StDrain:   if (eol_hs) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        pop_cnt_d = pop_cnt_q;
        if (accept) begin
            pop_cnt_d = '0;
        end else if (rd_en) begin
            pop_cnt_d = pop_cnt_q + 12'd1;
        end

        beat_d = beat_q;
        if (accept || eol_hs) begin
            beat_d = '0;
        end else if (hs) begin
            beat_d = beat_q + 12'd1;
        end

        vld_d[0] = rd_en;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
        end

        skid_cnt_d = skid_cnt_q + CntW'(skid_push) - CntW'(hs);
    end

    always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
        if (rd_rst_i) begin
            state_q     <= StIdle;
            pop_cnt_q   <= '0;
            beat_q      <= '0;
            vld_q       <= '0;
            skid_cnt_q  <= '0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pop_cnt_q   <= pop_cnt_d;
            beat_q      <= beat_d;
            vld_q       <= vld_d;
            skid_cnt_q  <= skid_cnt_d;
            line_done_q <= eol_hs;
        end
    end

    always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
        if (rd_rst_i) begin
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                skid_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (skid_push) begin
                skid_mem_q[wr_ptr_q] <= fifo_rd_data_i;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (hs) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign line_done_o  = line_done_q;
    assign underrun_o   = (state_q == StStream) & fifo_rd_empty_i;
    assign fifo_rd_en_o = rd_en;
    assign out_valid_o  = (skid_cnt_q != '0);
    assign out_data_o   = skid_mem_q[rd_ptr_q];
    assign out_sol_o    = out_valid_o & (beat_q == 12'd0);
    assign out_eol_o    = out_valid_o & (beat_q == LastBeat);

`ifdef FIFO_LINE_RD_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
        if (rd_rst_i) begin
            underrun_cnt_q <= '0;
        end else if (accept) begin
            underrun_cnt_q <= '0;
        end else if (underrun_o && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_line_rd_ctrl.sv
// Bench for fifo_line_rd_ctrl: FIFO model with 2-cycle read latency, line-level
// reference model checked every cycle, plus directed reset/underrun/ignored-request cases.
module tb_fifo_line_rd_ctrl;

    localparam int DW  = 32;
    localparam int DPW = 10;
    localparam int RDL = 2;
    localparam int LL  = 8;
    localparam int SL  = 16;
    localparam int SD  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          line_req;
    logic          busy, line_done, underrun, fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic [DPW:0]  fifo_rd_water_level;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          out_sol, out_eol;
`ifdef FIFO_LINE_RD_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    always #5 clk = ~clk;

    fifo_line_rd_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH_WIDTH(DPW),
        .RD_LATENCY (RDL),
        .LINE_LEN   (LL),
        .START_LEVEL(SL),
        .SKID_DEPTH (SD)
    ) dut (
        .rd_clk_i             (clk),
        .rd_rst_i             (rst),
        .line_req_i           (line_req),
        .busy_o               (busy),
        .line_done_o          (line_done),
        .underrun_o           (underrun),
        .fifo_rd_en_o         (fifo_rd_en),
        .fifo_rd_data_i       (fifo_rd_data),
        .fifo_rd_empty_i      (fifo_rd_empty),
        .fifo_rd_water_level_i(fifo_rd_water_level),
        .out_valid_o          (out_valid),
        .out_ready_i          (out_ready),
        .out_data_o           (out_data),
        .out_sol_o            (out_sol),
`ifdef FIFO_LINE_RD_UNDERRUN_CNT_EN
        .out_eol_o            (out_eol),
        .underrun_cnt_o       (underrun_cnt)
`else
        .out_eol_o            (out_eol)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // Line-level reference state: 0 idle, 1 waiting for level, 2 popping, 3 draining.
    int phase, pops_line, beats_line, cyc, done_cnt, stall_cnt, first_hs, last_hs;
    bit done_pend, pop_s;
    int pop_t[$];

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_mem [0:8191];
    int            exp_wr, exp_rd;
    logic [DW-1:0] d1;
    bit            lvl_force;
    int            lvl_val;

    typedef struct {
        int push;
        bit req;
        bit rdy;
        bit e_busy;
        bit e_rden;
        bit e_valid;
    } vec_t;
    vec_t tv[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void upd_lvl();
        fifo_rd_empty       = (fifo_q.size() == 0);
        fifo_rd_water_level = lvl_force ? (DPW + 1)'(lvl_val) : (DPW + 1)'(fifo_q.size());
    endfunction

    task automatic push(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom();
            fifo_q.push_back(w);
            exp_mem[exp_wr & 8191] = w;
            exp_wr++;
        end
        upd_lvl();
    endtask

    task automatic flush();
        fifo_q.delete();
        d1 = '0;
        fifo_rd_data = '0;
        upd_lvl();
    endtask

    // FIFO read port: data popped at an edge appears RDL cycles after the pop request.
    task automatic fifo_update();
        fifo_rd_data = d1;
        if (pop_s) begin
            check("pop_not_empty", 32'(fifo_q.size() != 0), 1);
            d1 = (fifo_q.size() != 0) ? fifo_q.pop_front() : $urandom();
        end else begin
            d1 = $urandom();
        end
        upd_lvl();
    endtask

    task automatic model_eval();
        int arrived;
        int ph0;
        bit ev, er, eu;
        if (rst) begin
            phase = 0; pops_line = 0; beats_line = 0; done_pend = 0; pop_s = 0;
            stall_cnt = 0;
            pop_t.delete();
            exp_rd = exp_wr;
            return;
        end
        ph0 = phase;
        arrived = 0;
        foreach (pop_t[i]) if (pop_t[i] + RDL + 1 <= cyc) arrived++;
        ev = (arrived > beats_line);
        er = (ph0 == 2) && !fifo_rd_empty && ((pops_line - beats_line) < SD);
        eu = (ph0 == 2) && fifo_rd_empty;
        check("out_valid", 32'(out_valid), 32'(ev));
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(er));
        check("underrun", 32'(underrun), 32'(eu));
        check("busy", 32'(busy), 32'(ph0 != 0));
        check("line_done", 32'(line_done), 32'(done_pend));
        if (!out_valid) begin
            check("sol_without_valid", 32'(out_sol), 0);
            check("eol_without_valid", 32'(out_eol), 0);
        end
        done_pend = 0;
        if (eu) stall_cnt++;
        pop_s = fifo_rd_en;
        if (fifo_rd_en) begin
            pop_t.push_back(cyc);
            pops_line++;
            if (pops_line == LL) phase = 3;
        end
        if (out_valid && out_ready) begin
            check("word_expected", 32'(exp_rd != exp_wr), 1);
            check("out_data", out_data, exp_mem[exp_rd & 8191]);
            exp_rd++;
            check("out_sol", 32'(out_sol), 32'(beats_line == 0));
            check("out_eol", 32'(out_eol), 32'(beats_line == LL - 1));
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            beats_line++;
            if (beats_line == LL) begin
                phase = 0; done_pend = 1; pops_line = 0; beats_line = 0;
                pop_t.delete();
                done_cnt++;
            end
        end
        if (ph0 == 1 && int'(fifo_rd_water_level) >= SL && !fifo_rd_empty) phase = 2;
        if (ph0 == 0 && line_req) begin
            phase = 1;
            stall_cnt = 0;
        end
        cyc++;
    endtask

    // Called at posedge+2 with stimulus applied; returns at the next posedge+2.
    task automatic cycle();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1 fifo_update();
        #1;
    endtask

    task automatic run_line(input int mode, input int budget);
        int n = 0;
        while ((phase != 0 || done_pend) && n < budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cycle();
            n++;
        end
        check("line_finished_in_budget", 32'(phase != 0 || done_pend), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_line_done"}, 32'(line_done), 0);
        check({tag, "_underrun"}, 32'(underrun), 0);
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_sol"}, 32'(out_sol), 0);
        check({tag, "_eol"}, 32'(out_eol), 0);
        check({tag, "_data"}, out_data, 0);
`ifdef FIFO_LINE_RD_UNDERRUN_CNT_EN
        check({tag, "_underrun_cnt"}, 32'(underrun_cnt), 0);
`endif
    endtask

    initial begin
        phase = 0; pops_line = 0; beats_line = 0; cyc = 0; done_cnt = 0; stall_cnt = 0;
        first_hs = -1; last_hs = -1; done_pend = 0; pop_s = 0;
        exp_wr = 0; exp_rd = 0; lvl_force = 0; lvl_val = 0;
        line_req = 1'b0; out_ready = 1'b0; d1 = '0; fifo_rd_data = '0;
        upd_lvl();

        #1 rst = 1'b1;
        #1 check_outputs_zero("reset");
        cycle();
        cycle();
        rst = 1'b0;

        // Level gating then a full line at ready=1 from a 20-word FIFO.
        tv = '{
            '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}
        };
        first_hs = -1;
        for (int i = 0; i < 8; i++) begin
            line_req  = tv[i].req;
            out_ready = tv[i].rdy;
            push(tv[i].push);
            #1;
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
            check($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(tv[i].e_rden));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tv[i].e_valid));
            cycle();
        end
        run_line(0, 40);
        check("leftover_words", 32'(fifo_q.size()), 12);
        check("back_to_back_span", 32'(last_hs - first_hs), LL - 1);
        check("lines_done_1", 32'(done_cnt), 1);

        // Alternating ready.
        push(16);
        out_ready = 1'b1;
        line_req = 1'b1;
        cycle();
        line_req = 1'b0;
        run_line(1, 80);
        check("lines_done_2", 32'(done_cnt), 2);

        // A second request while streaming must be ignored.
        line_req = 1'b1;
        cycle();
        line_req = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        line_req = 1'b1;
        cycle();
        line_req = 1'b0;
        run_line(2, 80);
        for (int i = 0; i < 3; i++) cycle();
        check("busy_after_ignored_req", 32'(busy), 0);
        check("lines_done_3", 32'(done_cnt), 3);

        // Reset in the middle of a line.
        push(8);
        out_ready = 1'b1;
        line_req = 1'b1;
        cycle();
        line_req = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1;
        #1 check_outputs_zero("midline_reset");
        flush();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // FIFO runs dry after three words, then refills.
        lvl_force = 1;
        lvl_val = 16;
        push(3);
        first_hs = -1;
        line_req = 1'b1;
        out_ready = 1'b1;
        cycle();
        line_req = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        check("underrun_observed", 32'(stall_cnt != 0), 1);
        lvl_force = 0;
        push(5);
        run_line(0, 60);
        check("lines_done_4", 32'(done_cnt), 4);
`ifdef FIFO_LINE_RD_UNDERRUN_CNT_EN
        check("underrun_cnt", 32'(underrun_cnt), 32'(stall_cnt));
`endif

        // Random traffic: pushes, ready and stray requests.
        for (int i = 0; i < 800; i++) begin
            line_req  = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) push(1);
            cycle();
        end
        line_req = 1'b0;
        push(16);
        run_line(0, 200);
        check("idle_at_end", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
